// File: rtl/parity_pkg.sv
// Shared definitions for the parity-framed serial link (receiver and transmitter).
// Contents:
//   ST_*            FSM state encodings
//   frame_bits()    bits per frame: start + data + parity + stop
package parity_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_DATA   = 2'd1;
  localparam logic [ST_W-1:0] ST_PARITY = 2'd2;
  localparam logic [ST_W-1:0] ST_STOP   = 2'd3;

  // Frame length for the default 8-bit word; use frame_bits() for other widths.
  localparam int unsigned FRAME_BITS_DEF = 8 + 3;

  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// Running parity accumulator with a parity-good check.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       zero the accumulator (takes priority over en)
//   en        XOR din into the accumulator
//   din       bit to accumulate
//   acc       current accumulator value
//   good      1 when acc XOR ODD_PAR is 0
module parity_acc
  import parity_pkg::*;
#(
  parameter bit ODD_PAR = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc,
  output logic good
);

  logic acc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign acc  = acc_q;
  assign good = ~(acc_q ^ ODD_PAR);

endmodule

// File: rtl/parity_frame_rx.sv
// Parity-framed serial receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Bits are consumed only on clock edges where bit_en is high.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bit_en      bit strobe
//   sin         serial line, idle high
//   data_out    last received word (held until the next frame completes)
//   data_valid  one-cycle pulse after the stop bit is sampled
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit was 0 on the last frame
//   busy        high whenever a frame is in progress
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter bit          ODD_PAR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [ST_W-1:0]   state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;

  logic acc_clr;
  logic acc_en;
  logic acc_val;
  logic par_good;
  logic stop_strobe;

  // Start bit seen: restart parity. Data and parity bits both fold into it.
  assign acc_clr     = bit_en && (state_q == ST_IDLE) && !sin;
  assign acc_en      = bit_en && ((state_q == ST_DATA) || (state_q == ST_PARITY));
  assign stop_strobe = bit_en && (state_q == ST_STOP);

  parity_acc #(
    .ODD_PAR (ODD_PAR)
  ) u_parity_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .din  (sin),
    .acc  (acc_val),
    .good (par_good)
  );

  // FSM, bit counter and data shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!sin) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
          end
        end
        ST_DATA: begin
          shreg_q <= {sin, shreg_q[DATA_W-1:1]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_PARITY;
          end
        end
        ST_PARITY: state_q <= ST_STOP;
        ST_STOP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Result registers load only when a frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (stop_strobe) begin
      data_q <= shreg_q;
      perr_q <= ~par_good;
      ferr_q <= ~sin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= stop_strobe;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

  // acc_val is visible for debug only.
  logic unused_acc;
  assign unused_acc = acc_val;

endmodule
